// File: rtl/rtp_result_pkg.sv
// Shared types for the ray-traversal result path: collector FSM states,
// the buffered result entry, and the default miss marker.
package rtp_result_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] MISS_T_DEFAULT = 32'h7F7FFFFF;

  typedef struct packed {
    logic [31:0] ray_id;
    logic [31:0] hitT;
  } result_entry_t;

  localparam int ENTRY_W = $bits(result_entry_t);

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with power-of-two depth; extra pointer bit tells full from empty.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag keeps stale words from being read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hit_result_collector.sv
// Collects traversal-core hit results, buffers them and writes hitT into the
// result RAM at the ray's address, keeping per-run statistics.
module hit_result_collector
  import rtp_result_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MISS_T     = MISS_T_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [31:0] cfg_ray_count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ray_id,
  input  logic [31:0] in_hitT,
  input  logic        rtp_finish,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] ray_done_cnt,
  output logic [31:0] miss_cnt,
  output logic [63:0] cycle_cnt,
  output logic        done,
  output logic        err_range,
  output logic        err_count
);

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   ray_count_q;
  logic          active;
  logic          start_run;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  result_entry_t push_entry;
  result_entry_t head;

  assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign start_run  = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_ready   = active && !fifo_full && !reset;
  assign accept     = in_valid && in_ready;
  assign in_range   = (in_ray_id < ray_count_q);
  assign push       = accept && in_range;
  assign push_entry = '{ray_id: in_ray_id, hitT: in_hitT};

  // Gating with reset keeps a buffered head from completing a write during reset.
  assign wr_valid   = !fifo_empty && !reset;
  assign pop        = wr_valid && wr_ready;
  assign wr_addr    = wr_valid ? head.ray_id : '0;
  assign wr_data    = wr_valid ? head.hitT   : '0;
  assign done       = (state_q == ST_DONE);

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_run),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: next-state defaults to the current state first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (cfg_start)  state_d = ST_RUN;
      ST_RUN:           if (rtp_finish) state_d = ST_DRAIN;
      ST_DRAIN:         if (fifo_empty && !push) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ray_count_q  <= '0;
      ray_done_cnt <= '0;
      miss_cnt     <= '0;
      cycle_cnt    <= '0;
      err_range    <= 1'b0;
      err_count    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        ray_count_q  <= cfg_ray_count;
        ray_done_cnt <= '0;
        miss_cnt     <= '0;
        cycle_cnt    <= '0;
        err_range    <= 1'b0;
        err_count    <= 1'b0;
      end else begin
        if (pop) begin
          ray_done_cnt <= sat_inc(ray_done_cnt);
          if (head.hitT == MISS_T) miss_cnt <= sat_inc(miss_cnt);
        end
        if (active)                 cycle_cnt <= cycle_cnt + 64'd1;
        if (accept && !in_range)    err_range <= 1'b1;
        // FIFO is empty on this transition, so ray_done_cnt is already final.
        if (state_q == ST_DRAIN && state_d == ST_DONE)
          err_count <= (ray_done_cnt != ray_count_q);
      end
    end
  end

endmodule

// File: tb/tb_hit_result_collector.sv
// Self-checking bench for hit_result_collector: scoreboard on the write port
// plus table-driven and hand-written run sequences.
module tb_hit_result_collector;
  import rtp_result_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MISS  = 32'h7F7FFFFF;
  localparam logic [31:0] ONE_F = 32'h3F800000;

  logic        clock;
  logic        reset;
  logic        cfg_start;
  logic [31:0] cfg_ray_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ray_id;
  logic [31:0] in_hitT;
  logic        rtp_finish;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] ray_done_cnt;
  logic [31:0] miss_cnt;
  logic [63:0] cycle_cnt;
  logic        done;
  logic        err_range;
  logic        err_count;

  hit_result_collector #(.FIFO_DEPTH(DEPTH), .MISS_T(MISS)) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_start     (cfg_start),
    .cfg_ray_count (cfg_ray_count),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ray_id     (in_ray_id),
    .in_hitT       (in_hitT),
    .rtp_finish    (rtp_finish),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .ray_done_cnt  (ray_done_cnt),
    .miss_cnt      (miss_cnt),
    .cycle_cnt     (cycle_cnt),
    .done          (done),
    .err_range     (err_range),
    .err_count     (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int            checks      = 0;
  int            errors      = 0;
  int            writes_seen = 0;
  longint        cyc         = 0;
  longint        cyc_start   = 0;
  logic [31:0]   model_count = '0;
  result_entry_t exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-port scoreboard; the write check runs before this cycle's push so a bypass shows up.
  always @(negedge clock) begin
    result_entry_t e;
    if (!reset) begin
      if (wr_valid && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wr_valid=1 addr=0x%0h with no pending result", wr_addr);
      end else if (wr_valid && wr_ready) begin
        e = exp_q.pop_front();
        check("wr_addr", {32'h0, wr_addr}, {32'h0, e.ray_id});
        check("wr_data", {32'h0, wr_data}, {32'h0, e.hitT});
        writes_seen++;
      end
      if (in_valid && in_ready && in_ray_id < model_count)
        exp_q.push_back('{ray_id: in_ray_id, hitT: in_hitT});
    end
  end

  // All sequence tasks start and end at 1 time unit after a rising edge.
  task automatic start_run(input logic [31:0] count);
    cfg_start     = 1'b1;
    cfg_ray_count = count;
    model_count   = count;
    @(posedge clock); #1;
    cfg_start = 1'b0;
    cyc_start = cyc;
  endtask

  task automatic send(input logic [31:0] id, input logic [31:0] hit);
    logic ok;
    int   n;
    in_valid  = 1'b1;
    in_ray_id = id;
    in_hitT   = hit;
    ok = 1'b0;
    n  = 0;
    do begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: id=%0d never accepted", id);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output longint cycles);
    int n;
    n = 0;
    rtp_finish = 1'b1;
    while (!done && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done not reached in 200 cycles");
    end
    cycles = cyc - cyc_start;
    rtp_finish = 1'b0;
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] hit;
    logic [31:0] exp_done;
    logic [31:0] exp_miss;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t   vecs[5];
    longint run_cycles;
    int     w0;

    vecs[0] = '{id: 32'd0, hit: MISS,  exp_done: 32'd1, exp_miss: 32'd1, exp_err: 1'b0};
    vecs[1] = '{id: 32'd1, hit: MISS,  exp_done: 32'd2, exp_miss: 32'd2, exp_err: 1'b0};
    vecs[2] = '{id: 32'd7, hit: ONE_F, exp_done: 32'd2, exp_miss: 32'd2, exp_err: 1'b1};
    vecs[3] = '{id: 32'd2, hit: MISS,  exp_done: 32'd3, exp_miss: 32'd3, exp_err: 1'b1};
    vecs[4] = '{id: 32'd3, hit: ONE_F, exp_done: 32'd4, exp_miss: 32'd3, exp_err: 1'b1};

    reset = 1'b1; cfg_start = 1'b0; cfg_ray_count = '0; in_valid = 1'b0;
    in_ray_id = '0; in_hitT = '0; rtp_finish = 1'b0; wr_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_ray_done", ray_done_cnt, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_done", done, 0);
    check("rst_errs", {err_range, err_count}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic run: four in-range results, RAM always ready.
    wr_ready = 1'b1;
    w0 = writes_seen;
    start_run(32'd4);
    for (int i = 0; i < 4; i++) send(i, 32'h40000000 + i);
    wait_done(run_cycles);
    @(negedge clock);
    check("basic_writes", writes_seen - w0, 4);
    check("basic_ray_done", ray_done_cnt, 4);
    check("basic_done", done, 1);
    check("basic_err_count", err_count, 0);
    check("basic_cycle_cnt", cycle_cnt, run_cycles);
    @(posedge clock); #1;

    // Table run from DONE: misses and an out-of-range id.
    start_run(32'd4);
    @(negedge clock);
    check("restart_cleared", {ray_done_cnt, miss_cnt}, 0);
    check("restart_done_low", done, 0);
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].id, vecs[i].hit);
      repeat (2) @(posedge clock);
      #1;
      check($sformatf("vec%0d_ray_done", i), ray_done_cnt, vecs[i].exp_done);
      check($sformatf("vec%0d_miss", i), miss_cnt, vecs[i].exp_miss);
      check($sformatf("vec%0d_err_range", i), err_range, vecs[i].exp_err);
    end
    wait_done(run_cycles);
    check("table_err_count", err_count, 0);
    check("table_err_range_sticky", err_range, 1);

    // Backpressure: fill the buffer, confirm stall and stable head, then drain in order.
    w0 = writes_seen;
    start_run(32'd10);
    wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(i, 32'h41000000 + i);
    in_valid = 1'b1; in_ray_id = 32'd8; in_hitT = 32'h41000008;
    repeat (3) begin
      @(negedge clock);
      check("full_in_ready", in_ready, 0);
      check("full_head_addr", wr_addr, 0);
      check("full_head_data", wr_data, 32'h41000000);
      @(posedge clock); #1;
    end
    wr_ready = 1'b1;
    send(32'd8, 32'h41000008);
    send(32'd9, 32'h41000009);
    wait_done(run_cycles);
    check("bp_writes", writes_seen - w0, 10);
    check("bp_ray_done", ray_done_cnt, 10);
    check("bp_queue_empty", exp_q.size(), 0);

    // Early finish: 3 of 4 rays.
    start_run(32'd4);
    for (int i = 0; i < 3; i++) send(i, 32'h42000000 + i);
    wait_done(run_cycles);
    @(negedge clock);
    check("short_done", done, 1);
    check("short_err_count", err_count, 1);
    check("short_ray_done", ray_done_cnt, 3);
    check("short_cycle_cnt", cycle_cnt, run_cycles);
    @(posedge clock); #1;

    // Reset with 5 entries buffered.
    start_run(32'd8);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i, 32'h43000000 + i);
    @(negedge clock);
    check("pre_reset_wr_valid", wr_valid, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("midrst_wr_valid_now", wr_valid, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_counts", {ray_done_cnt, miss_cnt}, 0);
    check("midrst_cycle_cnt", cycle_cnt, 0);
    check("midrst_flags", {done, err_range, err_count}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    wr_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("post_rst_wr_valid", wr_valid, 0);
    w0 = writes_seen;
    start_run(32'd2);
    send(32'd0, 32'h44000000);
    send(32'd1, MISS);
    wait_done(run_cycles);
    check("clean_writes", writes_seen - w0, 2);
    check("clean_ray_done", ray_done_cnt, 2);
    check("clean_miss", miss_cnt, 1);
    check("clean_err_count", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hit_result_collector.md
HIT_RESULT_COLLECTOR -- requirements
Module: hit_result_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, result-buffer entries (power of two, >=2).
REQ-002 Parameter MISS_T, default 32'h7F7FFFFF, hitT value that marks a miss.
REQ-003 clock  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_start  in  1  one-cycle pulse that starts a collection run.
REQ-006 cfg_ray_count  in  32  number of rays expected in the run; sampled on cfg_start.
REQ-007 in_valid  in  1  traversal core presents a hit result.
REQ-008 in_ready  out  1  collector accepts the result this cycle.
REQ-009 in_ray_id  in  32  ray index of the result (io_ray_id_triangle of the core).
REQ-010 in_hitT  in  32  IEEE-754 hit distance (io_hitT of the core).
REQ-011 rtp_finish  in  1  level from the core: traversal of all rays complete.
REQ-012 wr_valid  out  1  result-RAM write request.
REQ-013 wr_ready  in  1  result RAM accepts the write.
REQ-014 wr_addr  out  32  write address, equal to the ray id.
REQ-015 wr_data  out  32  hitT written.
REQ-016 ray_done_cnt  out  32  rays written to the RAM this run.
REQ-017 miss_cnt  out  32  written results whose hitT equals MISS_T.
REQ-018 cycle_cnt  out  64  cycles spent in RUN and DRAIN this run.
REQ-019 done  out  1  run complete; high while in DONE.
REQ-020 err_range  out  1  sticky: a result with ray id >= sampled ray count was dropped.
REQ-021 err_count  out  1  set on entry to DONE when ray_done_cnt != sampled ray count.

Function
REQ-022 FSM states IDLE, RUN, DRAIN, DONE; one state register.
REQ-023 IDLE: cfg_start -> RUN; sample cfg_ray_count; clear all counters, FIFO, err_range, err_count.
REQ-024 RUN: rtp_finish high -> DRAIN.
REQ-025 DRAIN: FIFO empty and no write in flight -> DONE.
REQ-026 DONE: cfg_start -> RUN with the same clearing as REQ-023; otherwise hold; all counters frozen.
REQ-027 cfg_start in RUN or DRAIN is ignored.
REQ-028 in_ready = (state is RUN or DRAIN) and FIFO not full; no same-cycle bypass when full.
REQ-029 Accepted result (in_valid & in_ready) with ray id < sampled count is pushed; it is visible on wr_valid no earlier than the next cycle.
REQ-030 Accepted result with ray id >= sampled count is consumed, not pushed, and sets err_range.
REQ-031 wr_valid = FIFO not empty; wr_addr/wr_data = head entry; pop on wr_valid & wr_ready.
REQ-032 wr_addr/wr_data are held stable while wr_valid and not wr_ready.
REQ-033 Simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged; push and pop pointers wrap modulo FIFO_DEPTH.
REQ-034 ray_done_cnt increments by 1 per pop; miss_cnt also increments by 1 if the popped hitT == MISS_T; both are 32-bit and saturate at all-ones.
REQ-035 cycle_cnt increments by 1 every cycle the FSM is in RUN or DRAIN; it is 64-bit and wraps.
REQ-036 done and err_count update in the same cycle the state becomes DONE.

Reset
REQ-037 While reset is high: state IDLE; FIFO empty; in_ready 0; wr_valid 0; wr_addr, wr_data, ray_done_cnt, miss_cnt, cycle_cnt 0; done, err_range, err_count 0.
REQ-038 Reset asserted mid-run discards buffered results without issuing further writes.

Structure
REQ-039 The state enum, MISS_T default, and the result-entry struct {ray_id[31:0], hitT[31:0]} are defined in a shared package rtp_result_pkg.
REQ-040 The FIFO is one sub-module, result_fifo: synchronous, parameterised depth and width, with full and empty outputs.

Verification
REQ-041 Use cfg_ray_count=4 and results ids 0..3 with wr_ready=1, then assert rtp_finish; expect 4 writes addr 0..3, ray_done_cnt=4, done=1, err_count=0.
REQ-042 Push 10 results with wr_ready=0 and FIFO_DEPTH=8; expect in_ready=0 after 8 accepts; release wr_ready; all 10 writes occur in order.
REQ-043 Send one result with id 7 when count=4; expect err_range=1, no write, ray_done_cnt unchanged.
REQ-044 Send 3 results with hitT=MISS_T and 1 with 32'h3F800000; expect miss_cnt=3 and ray_done_cnt=4.
REQ-045 Assert rtp_finish after only 3 of 4 rays; expect DONE with err_count=1; cycle_cnt equals the cycles spent in RUN plus DRAIN.
REQ-046 Pulse reset while 5 entries are buffered; expect no further wr_valid, all outputs at their reset values, and a clean restart on the next cfg_start.
